// File: rtl/seg_scan_capture.sv
// seg_scan_capture: rebuilds per-digit BCD content from a scanned 7-segment / digit-select bus.
// Optional build macro SEG_SCAN_LOST_EN adds a scan-timeout monitor and the scan_lost output.
module seg_scan_capture #(
    parameter int NUM_DIGITS    = 8,
    parameter int STABLE_FRAMES = 2,
    parameter int LOST_CYCLES   = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              segment_in,
    input  logic [7:0]              anode_ctrl_in,
    output logic [4*NUM_DIGITS-1:0] digit_val,
    output logic [NUM_DIGITS-1:0]   digit_blank,
    output logic                    frame_done,
    output logic                    err_anode,
    output logic                    err_pattern
`ifdef SEG_SCAN_LOST_EN
    ,
    output logic                    scan_lost
`endif
);

    localparam logic [2:0] STABLE_CNT = 3'(STABLE_FRAMES);

    typedef struct packed {
        logic       known;
        logic       blank;
        logic [3:0] nib;
    } dec_t;

    function automatic dec_t decode_seg(input logic [6:0] seg);
        dec_t d;
        d = '{known: 1'b1, blank: 1'b0, nib: 4'h0};
        case (seg)
            7'h3F:   d.nib = 4'd0;
            7'h06:   d.nib = 4'd1;
            7'h5B:   d.nib = 4'd2;
            7'h4F:   d.nib = 4'd3;
            7'h66:   d.nib = 4'd4;
            7'h6D:   d.nib = 4'd5;
            7'h7D:   d.nib = 4'd6;
            7'h07:   d.nib = 4'd7;
            7'h7F:   d.nib = 4'd8;
            7'h6F:   d.nib = 4'd9;
            7'h00:   d.blank = 1'b1;
            default: begin
                d.known = 1'b0;
                d.nib   = 4'hF;
            end
        endcase
        return d;
    endfunction

    // Input stage: segment/anode pairs captured on the same edge stay paired.
    logic [6:0] seg_q;
    logic [7:0] an_q;

    logic [3:0] low_cnt;
    logic [2:0] an_idx;
    logic       an_valid;
    logic       an_err;
    logic       in_range;
    logic       visit;

    logic       last_valid;
    logic [2:0] last_idx;
    logic       prev_valid;
    logic [2:0] prev_idx;

    logic [6:0] cand [NUM_DIGITS];
    logic [2:0] cnt  [NUM_DIGITS];

    logic [6:0] hit_cand;
    logic [2:0] hit_cnt;
    logic [2:0] new_cnt;
    logic       commit_now;
    dec_t       dec;

    logic       commit_v;
    logic [2:0] commit_idx;
    logic [3:0] commit_nib;
    logic       commit_blank;

    logic       lost_fire;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        low_cnt = 4'd0;
        an_idx  = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (!an_q[i]) begin
                low_cnt = low_cnt + 4'd1;
                an_idx  = 3'(i);
            end
        end
    end

    assign an_valid = (low_cnt == 4'd1);
    assign an_err   = (low_cnt > 4'd1);
    assign in_range = (int'(an_idx) < NUM_DIGITS);
    // A held index is one visit, so slow and 1-cycle scanners both advance the filter once.
    assign visit    = an_valid && (!last_valid || (an_idx != last_idx));
    assign dec      = decode_seg(seg_q);

    always_comb begin
        hit_cand = 7'h00;
        hit_cnt  = 3'd0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (int'(an_idx) == k) begin
                hit_cand = cand[k];
                hit_cnt  = lost_fire ? 3'd0 : cnt[k];
            end
        end
        if (seg_q == hit_cand) begin
            new_cnt = (hit_cnt >= STABLE_CNT) ? STABLE_CNT : hit_cnt + 3'd1;
        end else begin
            new_cnt = 3'd1;
        end
        commit_now = (new_cnt == STABLE_CNT);
    end

    // Visit stage: index tracking, pulses and the per-slot stability filter.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q        <= 7'h00;
            an_q         <= 8'hFF;
            last_valid   <= 1'b0;
            last_idx     <= 3'd0;
            prev_valid   <= 1'b0;
            prev_idx     <= 3'd0;
            frame_done   <= 1'b0;
            err_anode    <= 1'b0;
            err_pattern  <= 1'b0;
            commit_v     <= 1'b0;
            commit_idx   <= 3'd0;
            commit_nib   <= 4'h0;
            commit_blank <= 1'b1;
            // NOTE: the filter arrays are reset explicitly; a mid-scan reset must drop partial counts.
            for (int k = 0; k < NUM_DIGITS; k++) begin
                cand[k] <= 7'h00;
                cnt[k]  <= 3'd0;
            end
        end else begin
            seg_q        <= segment_in;
            an_q         <= anode_ctrl_in;
            last_valid   <= an_valid;
            last_idx     <= an_idx;
            err_anode    <= an_err;
            frame_done   <= visit && in_range && prev_valid && !lost_fire && (an_idx <= prev_idx);
            err_pattern  <= visit && in_range && !dec.known;
            commit_v     <= visit && in_range && commit_now;
            commit_idx   <= an_idx;
            commit_nib   <= dec.nib;
            commit_blank <= dec.blank;

            if (visit) begin
                prev_valid <= 1'b1;
                prev_idx   <= an_idx;
            end else if (lost_fire) begin
                prev_valid <= 1'b0;
            end

            for (int k = 0; k < NUM_DIGITS; k++) begin
                if (visit && in_range && (int'(an_idx) == k)) begin
                    cand[k] <= seg_q;
                    cnt[k]  <= new_cnt;
                end else if (lost_fire) begin
                    cnt[k] <= 3'd0;
                end
            end
        end
    end

    // Commit stage: a commit and a timeout never come from the same sample, but timeout wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            digit_val   <= '0;
            digit_blank <= '1;
        end else if (lost_fire) begin
            digit_val   <= '0;
            digit_blank <= '1;
        end else if (commit_v) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                if (int'(commit_idx) == k) begin
                    digit_val[4*k +: 4] <= commit_nib;
                    digit_blank[k]      <= commit_blank;
                end
            end
        end
    end

`ifdef SEG_SCAN_LOST_EN
    localparam int                LOST_W   = $clog2(LOST_CYCLES + 1);
    localparam logic [LOST_W-1:0] LOST_MAX = LOST_W'(LOST_CYCLES);
    localparam logic [LOST_W-1:0] LOST_PRE = LOST_W'(LOST_CYCLES - 1);

    logic [LOST_W-1:0] lost_cnt;
    logic              visit_q;

    // Fires once, on the sample that brings the idle count up to LOST_CYCLES.
    assign lost_fire = !visit_q && (lost_cnt == LOST_PRE);

    always_ff @(posedge clk) begin
        if (rst) begin
            visit_q   <= 1'b0;
            lost_cnt  <= '0;
            scan_lost <= 1'b0;
        end else begin
            visit_q <= visit;
            if (visit_q) begin
                lost_cnt  <= '0;
                scan_lost <= 1'b0;
            end else if (lost_cnt != LOST_MAX) begin
                lost_cnt <= lost_cnt + 1'b1;
                if (lost_fire) begin
                    scan_lost <= 1'b1;
                end
            end
        end
    end
`else
    assign lost_fire = 1'b0;
`endif

endmodule

// File: tb/tb_seg_scan_capture.sv
// tb_seg_scan_capture: directed and randomized scan traffic against a visit-level reference model.
// Build with SEG_SCAN_LOST_EN defined to also exercise the scan-timeout feature (LOST_CYCLES=16).
module tb_seg_scan_capture;

    localparam int N    = 8;
    localparam int S    = 2;
    localparam int LOST = 16;
    localparam bit [6:0] SEG_TAB [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                          7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    logic          clk           = 1'b0;
    logic          rst           = 1'b1;
    logic [6:0]    segment_in    = 7'h00;
    logic [7:0]    anode_ctrl_in = 8'hFF;
    logic [4*N-1:0] digit_val;
    logic [N-1:0]  digit_blank;
    logic          frame_done;
    logic          err_anode;
    logic          err_pattern;
`ifdef SEG_SCAN_LOST_EN
    logic          scan_lost;
`endif

    seg_scan_capture #(
        .NUM_DIGITS   (N),
        .STABLE_FRAMES(S),
        .LOST_CYCLES  (LOST)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .segment_in   (segment_in),
        .anode_ctrl_in(anode_ctrl_in),
        .digit_val    (digit_val),
        .digit_blank  (digit_blank),
        .frame_done   (frame_done),
        .err_anode    (err_anode),
        .err_pattern  (err_pattern)
`ifdef SEG_SCAN_LOST_EN
        ,
        .scan_lost    (scan_lost)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;
    int fd_seen, ea_seen, ep_seen;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: per-slot run length of identical visit patterns.
    bit [6:0]  run_pat [N];
    int        run_len [N];
    bit [31:0] m_val;
    bit [7:0]  m_blank;
    bit        m_lost;
    bit        last_ok;
    int        last_k;
    bit        have_prev;
    int        prev_k;
    int        idle_run;
    bit [31:0] val_h1, val_h2;
    bit [7:0]  blank_h1, blank_h2;
    bit        lost_h1, lost_h2;
    bit        fd_h1, ea_h1, ep_h1;

    function automatic int seg_to_digit(input bit [6:0] p);
        for (int i = 0; i < 10; i++) if (p == SEG_TAB[i]) return i;
        if (p == 7'h00) return 10;
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            run_pat[k] = 7'h00;
            run_len[k] = 0;
        end
        m_val = '0; m_blank = '1; m_lost = 1'b0;
        last_ok = 1'b0; last_k = 0; have_prev = 1'b0; prev_k = 0; idle_run = 0;
        val_h1 = '0; val_h2 = '0; blank_h1 = '1; blank_h2 = '1;
        lost_h1 = 1'b0; lost_h2 = 1'b0; fd_h1 = 1'b0; ea_h1 = 1'b0; ep_h1 = 1'b0;
    endtask

    task automatic model_sample(input bit [6:0] seg, input bit [7:0] an,
                                output bit fd, output bit ea, output bit ep);
        int  lows = 0;
        int  k    = 0;
        int  d;
        bit  vis  = 1'b0;
        fd = 1'b0; ea = 1'b0; ep = 1'b0;
        for (int i = 0; i < 8; i++) if (!an[i]) begin lows++; k = i; end
        if (lows == 1) begin
            vis = !last_ok || (k != last_k);
            last_ok = 1'b1;
            last_k = k;
        end else begin
            last_ok = 1'b0;
            ea = (lows > 1);
        end
        if (vis) begin
            idle_run = 0;
            m_lost = 1'b0;
            if (k < N) begin
                fd = have_prev && (k <= prev_k);
                d = seg_to_digit(seg);
                ep = (d < 0);
                if (seg == run_pat[k]) run_len[k]++;
                else begin run_pat[k] = seg; run_len[k] = 1; end
                if (run_len[k] >= S) begin
                    m_val[4*k +: 4] = (d < 0) ? 4'hF : (d == 10) ? 4'h0 : 4'(d);
                    m_blank[k] = (d == 10);
                end
            end
            have_prev = 1'b1;
            prev_k = k;
        end else if (idle_run < LOST) begin
            idle_run++;
`ifdef SEG_SCAN_LOST_EN
            if (idle_run == LOST) begin
                m_lost = 1'b1; m_val = '0; m_blank = '1; have_prev = 1'b0;
                for (int j = 0; j < N; j++) run_len[j] = 0;
            end
`endif
        end
    endtask

    task automatic step(input bit [6:0] seg, input bit [7:0] an);
        bit fd, ea, ep;
        @(negedge clk);
        segment_in = seg;
        anode_ctrl_in = an;
        @(posedge clk);
        #1;
        model_sample(seg, an, fd, ea, ep);
        check("frame_done", frame_done, fd_h1);
        check("err_anode", err_anode, ea_h1);
        check("err_pattern", err_pattern, ep_h1);
        check("digit_val", digit_val, val_h2);
        check("digit_blank", digit_blank, blank_h2);
`ifdef SEG_SCAN_LOST_EN
        check("scan_lost", scan_lost, lost_h2);
`endif
        fd_seen += int'(frame_done);
        ea_seen += int'(err_anode);
        ep_seen += int'(err_pattern);
        val_h2 = val_h1; val_h1 = m_val;
        blank_h2 = blank_h1; blank_h1 = m_blank;
        lost_h2 = lost_h1; lost_h1 = m_lost;
        fd_h1 = fd; ea_h1 = ea; ep_h1 = ep;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_digit_val", digit_val, 32'h0);
        check("rst_digit_blank", digit_blank, 8'hFF);
        check("rst_pulses", {frame_done, err_anode, err_pattern}, 3'b000);
`ifdef SEG_SCAN_LOST_EN
        check("rst_scan_lost", scan_lost, 1'b0);
`endif
        model_reset();
        rst = 1'b0;
        fd_seen = 0; ea_seen = 0; ep_seen = 0;
    endtask

    task automatic scan_frame(input bit [6:0] pats [8], input int hold);
        for (int k = 0; k < 8; k++) begin
            bit [7:0] an;
            an = ~(8'h01 << k);
            repeat (hold) step(pats[k], an);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(7'h00, 8'hFF);
    endtask

    function automatic bit [6:0] rand_pattern();
        int r = $urandom_range(99);
        if (r < 80) return SEG_TAB[$urandom_range(9)];
        if (r < 90) return 7'h00;
        return 7'($urandom_range(127));
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit [6:0] pats   [8];
        bit [6:0] digits [8];
        for (int k = 0; k < 8; k++) digits[k] = SEG_TAB[k];

        // 1-cycle scanner, slot0=4F, slot1=06, rest blank
        do_reset();
        pats = '{7'h4F, 7'h06, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
        scan_frame(pats, 1);
        scan_frame(pats, 1);
        idle(2);
        check("fast_val_2frames", digit_val, 32'h0000_0013);
        check("fast_blank_2frames", digit_blank, 8'hFC);
        scan_frame(pats, 1);
        idle(2);
        check("fast_val_3frames", digit_val, 32'h0000_0013);
        check("fast_frame_done_count", fd_seen, 2);

        // Slot0 alternating 3F/06 never settles, then 6D settles
        do_reset();
        pats = '{7'h3F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
        for (int f = 0; f < 6; f++) begin
            pats[0] = f[0] ? 7'h06 : 7'h3F;
            scan_frame(pats, 1);
        end
        idle(2);
        check("alt_val0", digit_val[3:0], 4'h0);
        check("alt_blank0", digit_blank[0], 1'b1);
        pats[0] = 7'h6D;
        scan_frame(pats, 1);
        scan_frame(pats, 1);
        idle(2);
        check("settle_val0", digit_val[3:0], 4'h5);
        check("settle_blank0", digit_blank[0], 1'b0);

        // Two-low anode glitch mid-scan
        do_reset();
        scan_frame(digits, 1);
        scan_frame(digits, 1);
        ea_seen = 0;
        for (int k = 0; k < 8; k++) begin
            bit [7:0] an;
            an = ~(8'h01 << k);
            step(digits[k], an);
            if (k == 3) step(7'h7F, 8'hFC);
        end
        scan_frame(digits, 1);
        idle(2);
        check("glitch_err_anode_count", ea_seen, 1);
        check("glitch_val", digit_val, 32'h7654_3210);
        check("glitch_blank", digit_blank, 8'h00);

        // Invalid pattern on slot2
        do_reset();
        pats = '{7'h00, 7'h00, 7'h49, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
        scan_frame(pats, 1);
        scan_frame(pats, 1);
        idle(2);
        check("badpat_err_count", ep_seen, 2);
        check("badpat_val2", digit_val[11:8], 4'hF);
        check("badpat_blank", digit_blank, 8'hFB);

        // Slow scanner, 5 cycles per anode, then reset mid-frame
        do_reset();
        pats = '{7'h7F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
        scan_frame(pats, 5);
        idle(2);
        check("slow_val0_1visit", digit_val[3:0], 4'h0);
        check("slow_blank0_1visit", digit_blank[0], 1'b1);
        scan_frame(pats, 5);
        idle(2);
        check("slow_val0_2visits", digit_val[3:0], 4'h8);
        for (int k = 0; k < 4; k++) begin
            bit [7:0] an;
            an = ~(8'h01 << k);
            repeat (5) step(digits[k], an);
        end
        do_reset();

        // Randomized traffic: irregular order, holds, idles, anode errors, bad patterns
        begin
            bit [6:0] disp [8];
            int k = 0;
            for (int i = 0; i < 8; i++) disp[i] = rand_pattern();
            for (int it = 0; it < 1500; it++) begin
                int       r    = $urandom_range(99);
                int       hold = $urandom_range(3, 1);
                bit [7:0] an;
                if ($urandom_range(99) < 10) k = $urandom_range(7);
                else k = (k + 1) % 8;
                if ($urandom_range(99) < 6) disp[k] = rand_pattern();
                an = ~(8'h01 << k);
                if (r < 6) an = 8'hFF;
                else if (r < 12) begin
                    int a = $urandom_range(7);
                    int b = (a + 1 + $urandom_range(6)) % 8;
                    an = ~((8'h01 << a) | (8'h01 << b));
                end
                repeat (hold) step(disp[k], an);
            end
            idle(2);
        end

`ifdef SEG_SCAN_LOST_EN
        // Scanner stops: timeout blanks everything, resumed scan recommits after 2 frames
        do_reset();
        scan_frame(digits, 1);
        scan_frame(digits, 1);
        idle(2);
        check("lost_pre_val", digit_val, 32'h7654_3210);
        idle(LOST + 2);
        check("lost_flag", scan_lost, 1'b1);
        check("lost_blank", digit_blank, 8'hFF);
        check("lost_val", digit_val, 32'h0);
        scan_frame(digits, 1);
        check("lost_cleared", scan_lost, 1'b0);
        check("lost_blank_1frame", digit_blank, 8'hFF);
        scan_frame(digits, 1);
        idle(2);
        check("lost_recommit_val", digit_val, 32'h7654_3210);
        check("lost_recommit_blank", digit_blank, 8'h00);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
